// File: rtl/plru_tree_update.sv
// plru_tree_update: per-set 3-bit tree pseudo-LRU store with victim decode and access update
module plru_tree_update #(
  parameter int index_bits = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  ready,
  input  logic [index_bits-1:0] lookup_index,
  output logic [2:0]            plru_bits,
  output logic [3:0]            victim_way,
  output logic [1:0]            victim_idx,
  input  logic                  access,
  input  logic [index_bits-1:0] access_index,
  input  logic [3:0]            access_way,
  output logic                  access_err
);
  localparam int sets = 1 << index_bits;
  typedef enum logic {INIT, RUN} state_t;
  state_t state, state_n;
  logic [2:0] mem [sets];
  logic [index_bits-1:0] cnt;
  logic [2:0] cur, upd;
  logic onehot, wr;
  assign plru_bits  = mem[lookup_index];
  assign victim_idx = plru_bits[0] ? (plru_bits[1] ? 2'd0 : 2'd1) : (plru_bits[2] ? 2'd2 : 2'd3);
  assign victim_way = 4'b0001 << victim_idx;
  assign ready      = state == RUN;
  assign cur        = mem[access_index];
  assign onehot     = access_way != 4'd0 && (access_way & (access_way - 4'd1)) == 4'd0;
  assign wr         = !reset && ready && access && onehot;
  always_comb begin
    state_n = (state == INIT && cnt == index_bits'(sets - 1)) ? RUN : state;
    upd     = access_way[0] ? {cur[2], 2'b00} :
              access_way[1] ? {cur[2], 2'b10} :
              access_way[2] ? {1'b0, cur[1], 1'b1} :
                              {1'b1, cur[1], 1'b1};
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= INIT;
      cnt        <= '0;
      access_err <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= state == INIT ? cnt + 1'b1 : cnt;
      access_err <= ready && access && !onehot;
    end
  end
  // Array has no reset: the INIT sweep is what clears it.
  always_ff @(posedge clk) begin
    if (!reset && state == INIT) mem[cnt] <= 3'b000;
    else if (wr) mem[access_index] <= upd;
  end
endmodule
